// File: rtl/branch_resolution_unit_pkg.sv
// Shared types for the branch resolution unit.
//   bru_state_e  : resolution FSM states
//   btb_update_t : one BTB update record {pc, target, taken}
//   shadow_cnt_width() : width of a down-counter that must hold a given value
package branch_resolution_unit_pkg;

  // Datapath width of the stored BTB update records. The top-level XLEN
  // parameter defaults to this and is expected to match it.
  localparam int BRU_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_SHADOW   = 2'd2
  } bru_state_e;

  typedef struct packed {
    logic [BRU_XLEN-1:0] pc;
    logic [BRU_XLEN-1:0] target;
    logic                taken;
  } btb_update_t;

  function automatic int shadow_cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/branch_resolution_unit_if.sv
// BTB update handshake bus between the branch resolution unit and the BTB.
//   o_btb_upd_valid  : head record valid (unit -> BTB)
//   i_btb_upd_ready  : BTB accepts the head record (BTB -> unit)
//   o_btb_upd_pc     : branch pc of the record
//   o_btb_upd_target : resolved target of the record
//   o_btb_upd_taken  : resolved direction of the record
interface branch_resolution_unit_if #(
  parameter int XLEN = 32
);
  logic            o_btb_upd_valid;
  logic            i_btb_upd_ready;
  logic [XLEN-1:0] o_btb_upd_pc;
  logic [XLEN-1:0] o_btb_upd_target;
  logic            o_btb_upd_taken;

  modport master (
    output o_btb_upd_valid,
    input  i_btb_upd_ready,
    output o_btb_upd_pc,
    output o_btb_upd_target,
    output o_btb_upd_taken
  );

  modport slave (
    input  o_btb_upd_valid,
    output i_btb_upd_ready,
    input  o_btb_upd_pc,
    input  o_btb_upd_target,
    input  o_btb_upd_taken
  );
endinterface

// File: rtl/branch_resolution_unit_btb_update_queue.sv
// btb_update_queue: small FIFO of BTB update records.
// Ports:
//   i_clk, i_reset   : clock, async active-high reset
//   i_push, i_push_data : enqueue request and record
//   i_pop_ready      : consumer ready; pops when the head is valid
//   o_head_valid, o_head : head record (zeroed when empty)
//   o_drop           : (BRANCH_PERF_COUNTERS_EN only) push discarded because full
// A push into a full queue is dropped unless a pop happens in the same cycle.
module btb_update_queue
  import branch_resolution_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_push,
  input  btb_update_t i_push_data,
  input  logic        i_pop_ready,
  output logic        o_head_valid,
  output btb_update_t o_head
`ifdef BRANCH_PERF_COUNTERS_EN
  ,
  output logic        o_drop
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  btb_update_t    mem_q [DEPTH];
  btb_update_t    mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic full;
  logic empty;
  logic pop;
  logic push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = !empty && i_pop_ready;
  // A pop frees a slot in the same cycle, so a full queue still accepts.
  assign push_ok = i_push && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_push_data;
      // DEPTH is a power of two, so the natural pointer overflow is the wrap.
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_head_valid = !empty;
  assign o_head       = empty ? '0 : mem_q[rd_ptr_q];

`ifdef BRANCH_PERF_COUNTERS_EN
  assign o_drop = i_push && full && !pop;
`endif

endmodule

// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit: resolves EX-stage branches/jumps against the IF
// prediction, issues a one-cycle registered redirect+flush on mispredict,
// drops SHADOW_CYCLES wrong-path cycles afterwards, and queues BTB updates.
// Ports:
//   i_clk, i_reset        : clock, async active-high reset
//   i_stall, i_valid      : EX hold / EX instruction valid
//   i_is_branch/jal/jalr  : one-hot control-flow type
//   i_cond_true           : branch comparison result
//   i_pc, i_imm, i_rs1    : operands
//   i_is_compressed       : 16-bit instruction (fallthrough pc+2)
//   i_predicted_taken/target : prediction from IF
//   i_trap_taken          : trap/mret this cycle, overrides everything
//   o_branch_taken, o_flush, o_branch_target : redirect to PC logic
//   btb_upd (master)      : BTB update handshake (head of update queue)
// Optional: BRANCH_PERF_COUNTERS_EN adds o_resolved_count,
//   o_mispredict_count, o_btbq_drop_count (32-bit, wrapping).
//
// state       | meaning
// ST_IDLE     | accepting resolves
// ST_REDIRECT | redirect/flush pulse is on the outputs
// ST_SHADOW   | dropping wrong-path cycles (counter frozen while stalled)
module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int XLEN          = BRU_XLEN,
  parameter int SHADOW_CYCLES = 2,
  parameter int BTBQ_DEPTH    = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_valid,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic             i_cond_true,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [XLEN-1:0]  i_rs1,
  input  logic             i_is_compressed,
  input  logic             i_predicted_taken,
  input  logic [XLEN-1:0]  i_predicted_target,
  input  logic             i_trap_taken,
  output logic             o_branch_taken,
  output logic [XLEN-1:0]  o_branch_target,
  output logic             o_flush,
  branch_resolution_unit_if.master btb_upd
`ifdef BRANCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]      o_resolved_count,
  output logic [31:0]      o_mispredict_count,
  output logic [31:0]      o_btbq_drop_count
`endif
);

  localparam int SC_W = shadow_cnt_width(SHADOW_CYCLES);

  bru_state_e      state_q, state_d;
  logic [SC_W-1:0] shadow_cnt_q, shadow_cnt_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            is_cf;
  logic            resolve;
  logic            actual_taken;
  logic [XLEN-1:0] actual_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] fallthrough;
  logic            mispredict;

  btb_update_t     push_data;
  btb_update_t     head;
  logic            head_valid;
  logic            push;

  assign is_cf   = i_is_branch || i_is_jal || i_is_jalr;
  assign resolve = i_valid && !i_stall && is_cf && (state_q == ST_IDLE) && !i_trap_taken;

  assign actual_taken  = (i_is_jal || i_is_jalr) ? 1'b1 : i_cond_true;
  assign jalr_sum      = i_rs1 + i_imm;
  assign actual_target = i_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (i_pc + i_imm);
  assign fallthrough   = i_pc + (i_is_compressed ? XLEN'(2) : XLEN'(4));

  assign mispredict = (actual_taken != i_predicted_taken) ||
                      (actual_taken && i_predicted_taken && (actual_target != i_predicted_target));

  always_comb begin
    state_d      = state_q;
    shadow_cnt_d = shadow_cnt_q;
    redirect_d   = 1'b0;
    target_d     = target_q;
    case (state_q)
      ST_IDLE: begin
        if (resolve && mispredict) begin
          state_d    = ST_REDIRECT;
          redirect_d = 1'b1;
          target_d   = actual_taken ? actual_target : fallthrough;
        end
      end
      ST_REDIRECT: begin
        if (SHADOW_CYCLES == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d      = ST_SHADOW;
          shadow_cnt_d = SC_W'(SHADOW_CYCLES);
        end
      end
      ST_SHADOW: begin
        if (!i_stall) begin
          if (shadow_cnt_q <= SC_W'(1)) begin
            state_d      = ST_IDLE;
            shadow_cnt_d = '0;
          end else begin
            shadow_cnt_d = shadow_cnt_q - SC_W'(1);
          end
        end
      end
      default: begin
        state_d      = ST_IDLE;
        shadow_cnt_d = '0;
      end
    endcase
    // Trap wins over any redirect in flight or being resolved now.
    if (i_trap_taken) begin
      state_d      = ST_IDLE;
      shadow_cnt_d = '0;
      redirect_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      shadow_cnt_q <= '0;
      redirect_q   <= 1'b0;
      target_q     <= '0;
    end else begin
      state_q      <= state_d;
      shadow_cnt_q <= shadow_cnt_d;
      redirect_q   <= redirect_d;
      target_q     <= target_d;
    end
  end

  assign o_branch_taken  = redirect_q;
  assign o_flush         = redirect_q;
  assign o_branch_target = target_q;

  // Correctly predicted not-taken branches carry nothing new for the BTB.
  assign push             = resolve && (actual_taken || mispredict);
  assign push_data.pc     = i_pc;
  assign push_data.target = actual_target;
  assign push_data.taken  = actual_taken;

`ifdef BRANCH_PERF_COUNTERS_EN
  logic q_drop;
`endif

  btb_update_queue #(
    .DEPTH (BTBQ_DEPTH)
  ) u_btbq (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (push),
    .i_push_data (push_data),
    .i_pop_ready (btb_upd.i_btb_upd_ready),
    .o_head_valid(head_valid),
    .o_head      (head)
`ifdef BRANCH_PERF_COUNTERS_EN
    ,
    .o_drop      (q_drop)
`endif
  );

  assign btb_upd.o_btb_upd_valid  = head_valid;
  assign btb_upd.o_btb_upd_pc     = head.pc;
  assign btb_upd.o_btb_upd_target = head.target;
  assign btb_upd.o_btb_upd_taken  = head.taken;

`ifdef BRANCH_PERF_COUNTERS_EN
  logic [31:0] resolved_cnt_q, resolved_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    resolved_cnt_d = resolved_cnt_q + (resolve ? 32'd1 : 32'd0);
    mispred_cnt_d  = mispred_cnt_q + ((resolve && mispredict) ? 32'd1 : 32'd0);
    drop_cnt_d     = drop_cnt_q + (q_drop ? 32'd1 : 32'd0);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      resolved_cnt_q <= '0;
      mispred_cnt_q  <= '0;
      drop_cnt_q     <= '0;
    end else begin
      resolved_cnt_q <= resolved_cnt_d;
      mispred_cnt_q  <= mispred_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign o_resolved_count   = resolved_cnt_q;
  assign o_mispredict_count = mispred_cnt_q;
  assign o_btbq_drop_count  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
module tb_branch_resolution_unit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stall;
  logic        i_valid;
  logic        i_is_branch;
  logic        i_is_jal;
  logic        i_is_jalr;
  logic        i_cond_true;
  logic [31:0] i_pc;
  logic [31:0] i_imm;
  logic [31:0] i_rs1;
  logic        i_is_compressed;
  logic        i_predicted_taken;
  logic [31:0] i_predicted_target;
  logic        i_trap_taken;
  logic        o_branch_taken;
  logic [31:0] o_branch_target;
  logic        o_flush;
`ifdef BRANCH_PERF_COUNTERS_EN
  logic [31:0] o_resolved_count;
  logic [31:0] o_mispredict_count;
  logic [31:0] o_btbq_drop_count;
`endif

  int checks = 0;
  int errors = 0;

  branch_resolution_unit_if #(.XLEN(32)) btb_upd ();

  branch_resolution_unit #(
    .XLEN(32), .SHADOW_CYCLES(2), .BTBQ_DEPTH(2)
  ) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_stall           (i_stall),
    .i_valid           (i_valid),
    .i_is_branch       (i_is_branch),
    .i_is_jal          (i_is_jal),
    .i_is_jalr         (i_is_jalr),
    .i_cond_true       (i_cond_true),
    .i_pc              (i_pc),
    .i_imm             (i_imm),
    .i_rs1             (i_rs1),
    .i_is_compressed   (i_is_compressed),
    .i_predicted_taken (i_predicted_taken),
    .i_predicted_target(i_predicted_target),
    .i_trap_taken      (i_trap_taken),
    .o_branch_taken    (o_branch_taken),
    .o_branch_target   (o_branch_target),
    .o_flush           (o_flush),
    .btb_upd           (btb_upd)
`ifdef BRANCH_PERF_COUNTERS_EN
    ,
    .o_resolved_count  (o_resolved_count),
    .o_mispredict_count(o_mispredict_count),
    .o_btbq_drop_count (o_btbq_drop_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_stall = 0; i_valid = 0; i_is_branch = 0; i_is_jal = 0; i_is_jalr = 0;
    i_cond_true = 0; i_pc = 0; i_imm = 0; i_rs1 = 0; i_is_compressed = 0;
    i_predicted_taken = 0; i_predicted_target = 0; i_trap_taken = 0;
  endtask

  // kind: 0 = branch, 1 = jal, 2 = jalr
  task automatic drive(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic cond, input logic cmp,
                       input logic ptaken, input logic [31:0] ptgt);
    i_valid = 1; i_is_branch = (kind == 0); i_is_jal = (kind == 1); i_is_jalr = (kind == 2);
    i_pc = pc; i_imm = imm; i_rs1 = rs1; i_cond_true = cond; i_is_compressed = cmp;
    i_predicted_taken = ptaken; i_predicted_target = ptgt;
  endtask

  task automatic idle_cycles(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    btb_upd.i_btb_upd_ready = 0;
    i_reset = 1;
    tick(); tick();
    checks++; if (o_branch_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b expected 0", o_branch_taken); end
    checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", o_flush); end
    checks++; if (o_branch_target !== 32'h0) begin errors++; $display("FAIL reset_target: got %h expected 0", o_branch_target); end
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid: got %b expected 0", btb_upd.o_btb_upd_valid); end
    checks++; if ({btb_upd.o_btb_upd_pc, btb_upd.o_btb_upd_target, btb_upd.o_btb_upd_taken} !== 65'h0) begin
      errors++; $display("FAIL reset_upd_payload: got %h/%h/%b expected 0", btb_upd.o_btb_upd_pc, btb_upd.o_btb_upd_target, btb_upd.o_btb_upd_taken); end
    i_reset = 0;
    tick();
  endtask

  task automatic test_beq_mispredict();
    btb_upd.i_btb_upd_ready = 0;
    drive(0, 32'h100, 32'h40, 32'h0, 1, 0, 0, 32'h0);
    tick();
    clear_inputs();
    checks++; if (o_branch_taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b expected 1", o_branch_taken); end
    checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL beq_flush: got %b expected 1", o_flush); end
    checks++; if (o_branch_target !== 32'h140) begin errors++; $display("FAIL beq_target: got %h expected 140", o_branch_target); end
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b1 || btb_upd.o_btb_upd_pc !== 32'h100 ||
                  btb_upd.o_btb_upd_target !== 32'h140 || btb_upd.o_btb_upd_taken !== 1'b1) begin
      errors++; $display("FAIL beq_queue: got v=%b %h/%h/%b expected v=1 100/140/1", btb_upd.o_btb_upd_valid,
                         btb_upd.o_btb_upd_pc, btb_upd.o_btb_upd_target, btb_upd.o_btb_upd_taken); end
    tick();
    checks++; if (o_branch_taken !== 1'b0 || o_flush !== 1'b0) begin
      errors++; $display("FAIL beq_pulse_width: got taken=%b flush=%b expected 0/0", o_branch_taken, o_flush); end
    btb_upd.i_btb_upd_ready = 1;
    tick();
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b0) begin errors++; $display("FAIL beq_pop: got %b expected 0", btb_upd.o_btb_upd_valid); end
    btb_upd.i_btb_upd_ready = 0;
    idle_cycles(3);
  endtask

  task automatic test_compressed_shadow();
    btb_upd.i_btb_upd_ready = 0;
    drive(0, 32'h202, 32'h10, 32'h0, 0, 1, 1, 32'h300);
    tick();
    checks++; if (o_branch_taken !== 1'b1 || o_branch_target !== 32'h204) begin
      errors++; $display("FAIL cmp_redirect: got taken=%b target=%h expected 1/204", o_branch_taken, o_branch_target); end
    checks++; if (btb_upd.o_btb_upd_pc !== 32'h202 || btb_upd.o_btb_upd_target !== 32'h212 || btb_upd.o_btb_upd_taken !== 1'b0) begin
      errors++; $display("FAIL cmp_queue: got %h/%h/%b expected 202/212/0", btb_upd.o_btb_upd_pc, btb_upd.o_btb_upd_target, btb_upd.o_btb_upd_taken); end
    // Redirect cycle plus two shadow cycles: mispredicting branches must be ignored.
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h600 + 32'(i * 16), 32'h20, 32'h0, 1, 0, 0, 32'h0);
      tick();
      checks++; if (o_branch_taken !== 1'b0) begin errors++; $display("FAIL shadow_ignore_%0d: got taken=%b expected 0", i, o_branch_taken); end
    end
    // Only the compressed branch's entry may be present: pop it and expect empty.
    clear_inputs();
    btb_upd.i_btb_upd_ready = 1;
    tick();
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b0) begin errors++; $display("FAIL shadow_no_push: got valid=%b expected 0", btb_upd.o_btb_upd_valid); end
    btb_upd.i_btb_upd_ready = 0;
    drive(0, 32'h700, 32'h8, 32'h0, 1, 0, 0, 32'h0);
    tick();
    checks++; if (o_branch_taken !== 1'b1 || o_branch_target !== 32'h708) begin
      errors++; $display("FAIL shadow_exit: got taken=%b target=%h expected 1/708", o_branch_taken, o_branch_target); end
    btb_upd.i_btb_upd_ready = 1;
    idle_cycles(4);
    btb_upd.i_btb_upd_ready = 0;
  endtask

  task automatic test_shadow_stall();
    drive(0, 32'h800, 32'h20, 32'h0, 1, 0, 0, 32'h0);
    tick();                       // REDIRECT
    clear_inputs();
    tick();                       // enter SHADOW with count 2
    i_stall = 1;
    drive(0, 32'h840, 32'h20, 32'h0, 1, 0, 0, 32'h0);
    tick(); tick(); tick();       // frozen
    i_stall = 0;
    tick();                       // count 2 -> 1, branch ignored
    checks++; if (o_branch_taken !== 1'b0) begin errors++; $display("FAIL stall_frozen_a: got taken=%b expected 0", o_branch_taken); end
    tick();                       // count 1 -> IDLE, branch ignored
    checks++; if (o_branch_taken !== 1'b0) begin errors++; $display("FAIL stall_frozen_b: got taken=%b expected 0", o_branch_taken); end
    tick();                       // resolved now
    checks++; if (o_branch_taken !== 1'b1 || o_branch_target !== 32'h860) begin
      errors++; $display("FAIL stall_resolve: got taken=%b target=%h expected 1/860", o_branch_taken, o_branch_target); end
    btb_upd.i_btb_upd_ready = 1;
    idle_cycles(4);
    btb_upd.i_btb_upd_ready = 0;
  endtask

  task automatic test_jalr();
    btb_upd.i_btb_upd_ready = 0;
    drive(2, 32'h500, 32'h4, 32'h1001, 0, 0, 1, 32'h1004);
    tick();
    clear_inputs();
    checks++; if (o_branch_taken !== 1'b0 || o_flush !== 1'b0) begin
      errors++; $display("FAIL jalr_no_redirect: got taken=%b flush=%b expected 0/0", o_branch_taken, o_flush); end
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b1 || btb_upd.o_btb_upd_pc !== 32'h500 ||
                  btb_upd.o_btb_upd_target !== 32'h1004 || btb_upd.o_btb_upd_taken !== 1'b1) begin
      errors++; $display("FAIL jalr_queue: got v=%b %h/%h/%b expected v=1 500/1004/1", btb_upd.o_btb_upd_valid,
                         btb_upd.o_btb_upd_pc, btb_upd.o_btb_upd_target, btb_upd.o_btb_upd_taken); end
    btb_upd.i_btb_upd_ready = 1;
    tick();
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b0) begin errors++; $display("FAIL jalr_single_push: got valid=%b expected 0", btb_upd.o_btb_upd_valid); end
    // Target mismatch with bit0 cleared: 0x2004 + 1 -> 0x2004.
    drive(2, 32'h520, 32'h1, 32'h2004, 0, 0, 1, 32'h2000);
    tick();
    clear_inputs();
    checks++; if (o_branch_taken !== 1'b1 || o_branch_target !== 32'h2004) begin
      errors++; $display("FAIL jalr_target_mispredict: got taken=%b target=%h expected 1/2004", o_branch_taken, o_branch_target); end
    idle_cycles(4);
    btb_upd.i_btb_upd_ready = 0;
  endtask

  task automatic test_queue_full();
    btb_upd.i_btb_upd_ready = 0;
    drive(1, 32'h10, 32'h20, 32'h0, 0, 0, 1, 32'h30);   tick();
    drive(1, 32'h40, 32'h100, 32'h0, 0, 0, 1, 32'h140); tick();
    drive(1, 32'h80, 32'h8, 32'h0, 0, 0, 1, 32'h88);    tick();
    clear_inputs();
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b1 || btb_upd.o_btb_upd_pc !== 32'h10 || btb_upd.o_btb_upd_target !== 32'h30) begin
      errors++; $display("FAIL full_head0: got v=%b %h/%h expected v=1 10/30", btb_upd.o_btb_upd_valid, btb_upd.o_btb_upd_pc, btb_upd.o_btb_upd_target); end
`ifdef BRANCH_PERF_COUNTERS_EN
    checks++; if (o_btbq_drop_count !== 32'd1) begin errors++; $display("FAIL full_drop_count: got %0d expected 1", o_btbq_drop_count); end
`endif
    btb_upd.i_btb_upd_ready = 1;
    tick();
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b1 || btb_upd.o_btb_upd_pc !== 32'h40 || btb_upd.o_btb_upd_target !== 32'h140) begin
      errors++; $display("FAIL full_head1: got v=%b %h/%h expected v=1 40/140", btb_upd.o_btb_upd_valid, btb_upd.o_btb_upd_pc, btb_upd.o_btb_upd_target); end
    tick();
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b0) begin errors++; $display("FAIL full_third_dropped: got valid=%b expected 0", btb_upd.o_btb_upd_valid); end
    btb_upd.i_btb_upd_ready = 0;
  endtask

  task automatic test_back_to_back();
    btb_upd.i_btb_upd_ready = 0;
    // Correctly predicted not-taken branch: no redirect, no push.
    drive(0, 32'h880, 32'h40, 32'h0, 0, 0, 0, 32'h0);
    tick();
    checks++; if (o_branch_taken !== 1'b0 || btb_upd.o_btb_upd_valid !== 1'b0) begin
      errors++; $display("FAIL nt_correct: got taken=%b valid=%b expected 0/0", o_branch_taken, btb_upd.o_btb_upd_valid); end
    drive(1, 32'h900, 32'h4, 32'h0, 0, 0, 1, 32'h904);  tick();
    drive(1, 32'h910, 32'h10, 32'h0, 0, 0, 1, 32'h920); tick();
    // Full queue with simultaneous pop: both accepted; negative imm wraps.
    btb_upd.i_btb_upd_ready = 1;
    drive(1, 32'h920, 32'hFFFF_FFF8, 32'h0, 0, 0, 1, 32'h918);
    tick();
    clear_inputs();
    checks++; if (btb_upd.o_btb_upd_pc !== 32'h910 || btb_upd.o_btb_upd_target !== 32'h920) begin
      errors++; $display("FAIL b2b_head1: got %h/%h expected 910/920", btb_upd.o_btb_upd_pc, btb_upd.o_btb_upd_target); end
    tick();
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b1 || btb_upd.o_btb_upd_pc !== 32'h920 || btb_upd.o_btb_upd_target !== 32'h918) begin
      errors++; $display("FAIL b2b_head2: got v=%b %h/%h expected v=1 920/918", btb_upd.o_btb_upd_valid, btb_upd.o_btb_upd_pc, btb_upd.o_btb_upd_target); end
    tick();
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got valid=%b expected 0", btb_upd.o_btb_upd_valid); end
    btb_upd.i_btb_upd_ready = 0;
  endtask

  task automatic test_trap();
    btb_upd.i_btb_upd_ready = 0;
    drive(0, 32'h300, 32'h40, 32'h0, 1, 0, 0, 32'h0);
    i_trap_taken = 1;
    tick();
    clear_inputs();
    checks++; if (o_branch_taken !== 1'b0 || o_flush !== 1'b0) begin
      errors++; $display("FAIL trap_cancel: got taken=%b flush=%b expected 0/0", o_branch_taken, o_flush); end
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b0) begin errors++; $display("FAIL trap_no_push: got valid=%b expected 0", btb_upd.o_btb_upd_valid); end
    drive(0, 32'h400, 32'h40, 32'h0, 1, 0, 0, 32'h0);
    tick();
    clear_inputs();
    checks++; if (o_branch_taken !== 1'b1 || o_branch_target !== 32'h440) begin
      errors++; $display("FAIL trap_idle_resolve: got taken=%b target=%h expected 1/440", o_branch_taken, o_branch_target); end
    i_trap_taken = 1;             // during REDIRECT: forces IDLE, skips shadow
    tick();
    i_trap_taken = 0;
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b1 || btb_upd.o_btb_upd_pc !== 32'h400) begin
      errors++; $display("FAIL trap_queue_survives: got v=%b pc=%h expected v=1 400", btb_upd.o_btb_upd_valid, btb_upd.o_btb_upd_pc); end
    drive(0, 32'h480, 32'h20, 32'h0, 1, 0, 0, 32'h0);
    tick();
    clear_inputs();
    checks++; if (o_branch_taken !== 1'b1 || o_branch_target !== 32'h4A0) begin
      errors++; $display("FAIL trap_skip_shadow: got taken=%b target=%h expected 1/4a0", o_branch_taken, o_branch_target); end
    btb_upd.i_btb_upd_ready = 1;
    tick();
    checks++; if (btb_upd.o_btb_upd_pc !== 32'h480 || btb_upd.o_btb_upd_target !== 32'h4A0) begin
      errors++; $display("FAIL trap_queue_order: got %h/%h expected 480/4a0", btb_upd.o_btb_upd_pc, btb_upd.o_btb_upd_target); end
    idle_cycles(4);
    btb_upd.i_btb_upd_ready = 0;
  endtask

  task automatic test_reset_in_shadow();
    btb_upd.i_btb_upd_ready = 0;
    drive(0, 32'hA00, 32'h40, 32'h0, 1, 0, 0, 32'h0);
    tick();
    clear_inputs();
    tick();                       // now in SHADOW, one queue entry held
    i_reset = 1;
    #1;
    checks++; if (o_branch_taken !== 1'b0 || o_flush !== 1'b0 || o_branch_target !== 32'h0) begin
      errors++; $display("FAIL rst_shadow_outputs: got taken=%b flush=%b target=%h expected 0/0/0", o_branch_taken, o_flush, o_branch_target); end
    checks++; if (btb_upd.o_btb_upd_valid !== 1'b0 || btb_upd.o_btb_upd_pc !== 32'h0) begin
      errors++; $display("FAIL rst_shadow_queue: got v=%b pc=%h expected 0/0", btb_upd.o_btb_upd_valid, btb_upd.o_btb_upd_pc); end
    tick();
    i_reset = 0;
    tick();
    checks++; if (o_branch_taken !== 1'b0) begin errors++; $display("FAIL rst_no_pulse: got taken=%b expected 0", o_branch_taken); end
    drive(0, 32'hB00, 32'h10, 32'h0, 1, 0, 0, 32'h0);
    tick();
    clear_inputs();
    checks++; if (o_branch_taken !== 1'b1 || o_branch_target !== 32'hB10 || btb_upd.o_btb_upd_pc !== 32'hB00) begin
      errors++; $display("FAIL rst_then_resolve: got taken=%b target=%h qpc=%h expected 1/b10/b00", o_branch_taken, o_branch_target, btb_upd.o_btb_upd_pc); end
    idle_cycles(4);
  endtask

  initial begin
    i_reset = 1;
    clear_inputs();
    btb_upd.i_btb_upd_ready = 0;
    test_reset();
    test_beq_mispredict();
    test_compressed_shadow();
    test_shadow_stall();
    test_jalr();
    test_queue_full();
    test_back_to_back();
    test_trap();
    test_reset_in_shadow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_resolution_unit.md
BRANCH_RESOLUTION_UNIT -- requirements
Module: branch_resolution_unit

Interface
REQ-001 SHALL have parameters: XLEN, default 32, datapath width; SHADOW_CYCLES, default 2, wrong-path cycles dropped after a redirect; BTBQ_DEPTH, default 2, BTB-update queue entries (power of two, >=2).
REQ-002 SHALL use one clock; reset is asynchronous and active-high; ports i_clk and i_reset.
REQ-003 Ports:
- i_clk, in, 1, clock.
- i_reset, in, 1, async active-high reset.
- i_stall, in, 1, EX holds.
- i_valid, in, 1, EX instruction valid.
- i_is_branch / i_is_jal / i_is_jalr, in, 1 each, one-hot control-flow type.
- i_cond_true, in, 1, branch comparison result.
- i_pc / i_imm / i_rs1, in, XLEN each, operands.
- i_is_compressed, in, 1, 16-bit instruction.
- i_predicted_taken, in, 1, prediction carried from IF.
- i_predicted_target, in, XLEN, prediction carried from IF.
- i_trap_taken, in, 1, trap/mret this cycle.
- o_branch_taken, out, 1, redirect pulse to PC logic.
- o_branch_target, out, XLEN, redirect address.
- o_flush, out, 1, squash younger stages.
- o_btb_upd_valid, out, 1, BTB update handshake valid.
- i_btb_upd_ready, in, 1, BTB update handshake ready.
- o_btb_upd_pc / o_btb_upd_target, out, XLEN each, update payload.
- o_btb_upd_taken, out, 1, update payload.

Function
REQ-004 Resolve = i_valid && !i_stall && type bit set && state==IDLE && !i_trap_taken.
REQ-005 Actual taken SHALL be 1 for JAL/JALR and i_cond_true for branches.
REQ-006 Actual target SHALL be i_pc+i_imm for branch/JAL and (i_rs1+i_imm) with bit0 cleared for JALR, modulo 2^XLEN.
REQ-007 Fallthrough SHALL be i_pc+2 if compressed, else i_pc+4.
REQ-008 Mispredict = taken mismatch, or both taken with target != i_predicted_target.
REQ-009 On mispredict, o_branch_taken and o_flush SHALL pulse exactly one cycle, in the cycle after resolve (registered, latency 1).
REQ-010 o_branch_target SHALL be the actual target if taken, else the fallthrough.
REQ-011 FSM states:
- IDLE.
- REDIRECT: the output-pulse cycle.
- SHADOW: counts SHADOW_CYCLES non-stalled cycles; i_valid is ignored; counter frozen on i_stall; then returns to IDLE.
- SHADOW_CYCLES=0 SHALL go REDIRECT->IDLE.
REQ-012 i_trap_taken SHALL force IDLE next cycle, cancel any redirect pulse due next cycle, and take priority over a simultaneous resolve.
REQ-013 Every resolve that is taken or mispredicted SHALL push {pc, actual target, actual taken} into the BTB queue.
REQ-014 The queue SHALL be a FIFO presenting its head on o_btb_upd_*; pop on valid&&ready.
REQ-015 Queue full SHALL drop the newest push; a simultaneous pop and push when full SHALL accept both.
REQ-016 Queue contents SHALL survive i_trap_taken and redirects.
REQ-017 Queue pointers SHALL wrap modulo BTBQ_DEPTH with a separate full/empty count.

Reset
REQ-018 Reset SHALL set state IDLE, shadow counter 0, queue empty, o_branch_taken=0, o_flush=0, o_btb_upd_valid=0, and o_branch_target/payload outputs=0.
REQ-019 Reset mid-SHADOW or with a redirect pending SHALL abort with no pulse after release.

Configuration
REQ-020 With BRANCH_PERF_COUNTERS_EN defined, the unit SHALL add 32-bit wrapping outputs o_resolved_count, o_mispredict_count and o_btbq_drop_count, all reset to 0.
REQ-021 Without BRANCH_PERF_COUNTERS_EN, these ports and their logic SHALL be absent.

Structure
REQ-022 The shared cpu package SHALL hold the FSM state enum and the btb_update_t struct {pc, target, taken}.
REQ-023 The queue SHALL be a sub-module btb_update_queue.

Verification
REQ-024 BEQ at pc 0x100, imm 0x40, cond true, predicted not-taken -> next cycle o_branch_taken=1, target 0x140, o_flush=1; queue gets {0x100,0x140,1}.
REQ-025 Compressed branch at 0x202, predicted taken to 0x300, cond false -> redirect to 0x204; then 2 valid branches ignored.
REQ-026 JALR with rs1 0x1001, imm 4, correctly predicted 0x1004 -> no redirect; one queue push.
REQ-027 Three taken resolves with ready=0, depth 2 -> 2 entries held, drop count 1; ready=1 drains in order.
REQ-028 Mispredict resolve with i_trap_taken same cycle -> no redirect; state IDLE.
REQ-029 Reset asserted during SHADOW -> all outputs 0, queue empty, next resolve handled normally.
